// File: rtl/conv_out_streamer.sv
// Snapshots the parallel convolution result after a programmable settle delay and
// streams it pixel-by-pixel (row-major) over valid/ready. Optional: CONV_OUT_STREAMER_CHECKSUM_EN.
module conv_out_streamer #(
  parameter int PIX_W         = 13,
  parameter int OUT_W         = 30,
  parameter int OUT_H         = 30,
  parameter int CAPTURE_DELAY = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [OUT_H*OUT_W*PIX_W-1:0]   in_im,
  output logic                           busy,
  output logic [PIX_W-1:0]               pix_data,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic [4:0]                     pix_row,
  output logic [4:0]                     pix_col,
  output logic                           pix_eol,
  output logic                           pix_last,
  output logic                           frame_done
`ifdef CONV_OUT_STREAMER_CHECKSUM_EN
  ,
  output logic [15:0]                    checksum
`endif
);

  localparam int NPIX  = OUT_W * OUT_H;
  localparam int BUS_W = NPIX * PIX_W;
  localparam int CW    = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM
  } state_t;

  state_t           state_q;
  logic [BUS_W-1:0] snap_q;
  logic [CW-1:0]    cnt_q;
  logic [4:0]       row_q, col_q;
  logic [4:0]       row_d, col_d;
  logic             busy_q, valid_q, eol_q, last_q, done_q;
  logic             hs, capture;
`ifdef CONV_OUT_STREAMER_CHECKSUM_EN
  logic [15:0]      sum_q;
`endif

  assign hs = valid_q && pix_ready;

  always_comb begin
    col_d = (col_q == 5'(OUT_W - 1)) ? '0 : col_q + 5'd1;
    row_d = (col_q == 5'(OUT_W - 1)) ? row_q + 5'd1 : row_q;
  end

  // Capture happens on the acceptance edge itself when no settle delay is configured.
  always_comb begin
    capture = 1'b0;
    if (state_q == S_IDLE && start && CAPTURE_DELAY == 0) capture = 1'b1;
    if (state_q == S_WAIT && cnt_q <= CW'(1))             capture = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CONV_OUT_STREAMER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q <= CW'(CAPTURE_DELAY);
`ifdef CONV_OUT_STREAMER_CHECKSUM_EN
            sum_q <= '0;
`endif
            if (!capture) begin
              state_q <= S_WAIT;
              busy_q  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!capture) cnt_q <= cnt_q - CW'(1);
        end
        S_STREAM: begin
          if (hs) begin
            snap_q <= snap_q >> PIX_W;
`ifdef CONV_OUT_STREAMER_CHECKSUM_EN
            sum_q  <= sum_q + 16'(snap_q[PIX_W-1:0]);
`endif
            if (last_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              row_q   <= '0;
              col_q   <= '0;
              eol_q   <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              row_q  <= row_d;
              col_q  <= col_d;
              eol_q  <= (col_d == 5'(OUT_W - 1));
              last_q <= (row_d == 5'(OUT_H - 1)) && (col_d == 5'(OUT_W - 1));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (capture) begin
        state_q <= S_STREAM;
        busy_q  <= 1'b1;
        valid_q <= 1'b1;
        snap_q  <= in_im;
        row_q   <= '0;
        col_q   <= '0;
        eol_q   <= (OUT_W == 1);
        last_q  <= (NPIX == 1);
      end
    end
  end

  assign busy       = busy_q;
  assign pix_data   = snap_q[PIX_W-1:0];
  assign pix_valid  = valid_q;
  assign pix_row    = row_q;
  assign pix_col    = col_q;
  assign pix_eol    = eol_q;
  assign pix_last   = last_q;
  assign frame_done = done_q;
`ifdef CONV_OUT_STREAMER_CHECKSUM_EN
  assign checksum   = sum_q;
`endif

endmodule

// File: tb/tb_conv_out_streamer.sv
// Directed bench for conv_out_streamer: ramp frame, backpressure, snapshot isolation,
// start filtering / back-to-back, mid-frame reset and zero capture delay.
module tb_conv_out_streamer;
  localparam int PW = 13;
  localparam int W  = 30;
  localparam int H  = 30;
  localparam int N  = W * H;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            pix_ready = 1'b0;
  logic [N*PW-1:0] in_im;
  logic            busy, pix_valid, pix_eol, pix_last, frame_done;
  logic [PW-1:0]   pix_data;
  logic [4:0]      pix_row, pix_col;

  logic            start0 = 1'b0;
  logic            ready0 = 1'b0;
  logic            busy0, valid0, eol0, last0, done0;
  logic [PW-1:0]   data0;
  logic [4:0]      row0, col0;
`ifdef CONV_OUT_STREAMER_CHECKSUM_EN
  logic [15:0]     checksum, checksum0;
`endif

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  conv_out_streamer #(.PIX_W(PW), .OUT_W(W), .OUT_H(H), .CAPTURE_DELAY(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_im(in_im), .busy(busy),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_row(pix_row), .pix_col(pix_col), .pix_eol(pix_eol), .pix_last(pix_last),
    .frame_done(frame_done)
`ifdef CONV_OUT_STREAMER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  conv_out_streamer #(.PIX_W(PW), .OUT_W(W), .OUT_H(H), .CAPTURE_DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .in_im(in_im), .busy(busy0),
    .pix_data(data0), .pix_valid(valid0), .pix_ready(ready0),
    .pix_row(row0), .pix_col(col0), .pix_eol(eol0), .pix_last(last0),
    .frame_done(done0)
`ifdef CONV_OUT_STREAMER_CHECKSUM_EN
    , .checksum(checksum0)
`endif
  );

  // Expected {data,row,col,eol,last} for ramp pixel k.
  function automatic logic [24:0] exp_pix(input int k);
    return {PW'(k), 5'(k / W), 5'(k % W), (k % W) == W - 1, k == N - 1};
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) in_im[PW*i +: PW] = PW'(i);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fill_ramp();
    rst_n = 1'b0;
    pix_ready = 1'b1;
    repeat (3) step();
    tests_run++;
    if ({busy, pix_valid, pix_eol, pix_last, frame_done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got %b want 00000", {busy, pix_valid, pix_eol, pix_last, frame_done});
    end
    tests_run++;
    if ({pix_data, pix_row, pix_col} !== 23'd0) begin
      failures++;
      $display("FAIL reset_data got %h want 0", {pix_data, pix_row, pix_col});
    end
    rst_n = 1'b1;
    pix_ready = 1'b0;
    step();
    pix_ready = 1'b1;
    step();
    tests_run++;
    if ({busy, pix_valid, frame_done} !== 3'b0) begin
      failures++;
      $display("FAIL idle_ready_toggle got %b want 000", {busy, pix_valid, frame_done});
    end
  endtask

  task automatic test_ramp();
    int lat;
    pix_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    tests_run++;
    if ({busy, pix_valid} !== 2'b10) begin
      failures++;
      $display("FAIL ramp_wait got busy,valid=%b want 10", {busy, pix_valid});
    end
    lat = 0;
    while (!pix_valid && lat < 10) begin step(); lat++; end
    tests_run++;
    if (lat != 2) begin
      failures++;
      $display("FAIL ramp_latency got %0d want 2", lat);
    end
    for (int k = 0; k < N; k++) begin
      tests_run++;
      if ({pix_data, pix_row, pix_col, pix_eol, pix_last} !== exp_pix(k) || pix_valid !== 1'b1) begin
        failures++;
        $display("FAIL ramp_pix%0d got %h valid %b want %h", k,
                 {pix_data, pix_row, pix_col, pix_eol, pix_last}, pix_valid, exp_pix(k));
      end
      step();
    end
    tests_run++;
    if ({frame_done, pix_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL ramp_done got done,valid,busy=%b want 100", {frame_done, pix_valid, busy});
    end
`ifdef CONV_OUT_STREAMER_CHECKSUM_EN
    tests_run++;
    if (checksum !== 16'h2C46) begin
      failures++;
      $display("FAIL ramp_checksum got %h want 2c46", checksum);
    end
`endif
    step();
    tests_run++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width got %b want 0", frame_done);
    end
`ifdef CONV_OUT_STREAMER_CHECKSUM_EN
    tests_run++;
    if (checksum !== 16'h2C46) begin
      failures++;
      $display("FAIL checksum_hold got %h want 2c46", checksum);
    end
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    pix_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!pix_valid && lat < 10) begin step(); lat++; end
    for (int k = 0; k < 31; k++) step();
    pix_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tests_run++;
      if ({pix_data, pix_row, pix_col, pix_eol, pix_last} !== exp_pix(31) || pix_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall%0d got %h valid %b want %h", s,
                 {pix_data, pix_row, pix_col, pix_eol, pix_last}, pix_valid, exp_pix(31));
      end
      step();
    end
    pix_ready = 1'b1;
    for (int k = 31; k < N; k++) begin
      tests_run++;
      if ({pix_data, pix_row, pix_col, pix_eol, pix_last} !== exp_pix(k) || pix_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_pix%0d got %h want %h", k,
                 {pix_data, pix_row, pix_col, pix_eol, pix_last}, exp_pix(k));
      end
      step();
    end
    tests_run++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL bp_done got %b want 1", frame_done);
    end
  endtask

  task automatic test_isolation();
    int lat;
    pix_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!pix_valid && lat < 10) begin step(); lat++; end
    in_im = '1;
    for (int k = 0; k < N; k++) begin
      tests_run++;
      if ({pix_data, pix_row, pix_col, pix_eol, pix_last} !== exp_pix(k)) begin
        failures++;
        $display("FAIL iso_pix%0d got %h want %h", k,
                 {pix_data, pix_row, pix_col, pix_eol, pix_last}, exp_pix(k));
      end
      step();
    end
    tests_run++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL iso_done got %b want 1", frame_done);
    end
    fill_ramp();
    step();
  endtask

  task automatic test_back_to_back();
    int lat, cnt, dones, cyc;
    pix_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    dones = 0;
    cyc = 0;
    while (dones == 0 && cyc < 1200) begin
      if (pix_valid) begin
        tests_run++;
        if ({pix_data, pix_row, pix_col, pix_eol, pix_last} !== exp_pix(cnt % N)) begin
          failures++;
          $display("FAIL b2b_pix%0d got %h want %h", cnt,
                   {pix_data, pix_row, pix_col, pix_eol, pix_last}, exp_pix(cnt % N));
        end
        cnt++;
      end
      start = (cnt == 101);
      if (frame_done) begin
        dones++;
        start = 1'b1;
      end
      if (dones == 0) step();
      cyc++;
    end
    tests_run++;
    if (cnt != N || dones != 1) begin
      failures++;
      $display("FAIL start_ignored got %0d pixels %0d dones want %0d and 1", cnt, dones, N);
    end
    step();
    start = 1'b0;
    lat = 0;
    while (!pix_valid && lat < 10) begin step(); lat++; end
    tests_run++;
    if (lat != 2 || {pix_data, pix_row, pix_col, pix_eol, pix_last} !== exp_pix(0)) begin
      failures++;
      $display("FAIL b2b_second_start got lat %0d pix %h want 2 %h", lat,
               {pix_data, pix_row, pix_col, pix_eol, pix_last}, exp_pix(0));
    end
    cnt = 0;
    cyc = 0;
    while (!frame_done && cyc < 1200) begin
      if (pix_valid) cnt++;
      step();
      cyc++;
    end
    tests_run++;
    if (cnt != N || frame_done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_frame got %0d pixels done %b want %0d 1", cnt, frame_done, N);
    end
    step();
  endtask

  task automatic test_reset_midframe();
    int lat, cnt, cyc;
    pix_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!pix_valid && lat < 10) begin step(); lat++; end
    for (int k = 0; k < 400; k++) step();
    tests_run++;
    if ({pix_data, pix_row, pix_col, pix_eol, pix_last} !== exp_pix(400)) begin
      failures++;
      $display("FAIL pre_reset_pix got %h want %h",
               {pix_data, pix_row, pix_col, pix_eol, pix_last}, exp_pix(400));
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tests_run++;
      if ({pix_valid, busy, frame_done} !== 3'b000) begin
        failures++;
        $display("FAIL abort%0d got valid,busy,done=%b want 000", s, {pix_valid, busy, frame_done});
      end
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!pix_valid && lat < 10) begin step(); lat++; end
    tests_run++;
    if (lat != 2 || {pix_data, pix_row, pix_col, pix_eol, pix_last} !== exp_pix(0)) begin
      failures++;
      $display("FAIL restream_first got lat %0d pix %h want 2 %h", lat,
               {pix_data, pix_row, pix_col, pix_eol, pix_last}, exp_pix(0));
    end
    cnt = 0;
    cyc = 0;
    while (!frame_done && cyc < 1200) begin
      if (pix_valid) cnt++;
      step();
      cyc++;
    end
    tests_run++;
    if (cnt != N || frame_done !== 1'b1) begin
      failures++;
      $display("FAIL restream_frame got %0d pixels done %b want %0d 1", cnt, frame_done, N);
    end
    step();
  endtask

  task automatic test_delay0();
    ready0 = 1'b0;
    tests_run++;
    if ({valid0, busy0} !== 2'b00) begin
      failures++;
      $display("FAIL d0_idle got valid,busy=%b want 00", {valid0, busy0});
    end
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    tests_run++;
    if ({valid0, busy0} !== 2'b11 || {data0, row0, col0, eol0, last0} !== exp_pix(0)) begin
      failures++;
      $display("FAIL d0_first got valid,busy=%b pix %h want 11 %h", {valid0, busy0},
               {data0, row0, col0, eol0, last0}, exp_pix(0));
    end
    ready0 = 1'b1;
    step();
    tests_run++;
    if ({data0, row0, col0, eol0, last0} !== exp_pix(1)) begin
      failures++;
      $display("FAIL d0_second got %h want %h", {data0, row0, col0, eol0, last0}, exp_pix(1));
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_ramp();
    test_backpressure();
    test_isolation();
    test_back_to_back();
    test_reset_midframe();
    test_delay0();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/conv_out_streamer.md
Name: conv_out_streamer

Overview:
- Sink-side companion to the 30x30 convolution array.
- On a start pulse, waits a programmable number of cycles for the MAC pipeline to settle, then snapshots the full parallel result bus.
- Streams the result as 900 pixels in row-major order over a valid/ready interface to the downstream writer/DMA.
- Decouples the wide combinational-width result from the narrow serial consumer so the next frame can be computed while the current one drains.

Parameters:
- PIX_W, 13, bits per output pixel.
- OUT_W, 30, output columns per row.
- OUT_H, 30, output rows.
- CAPTURE_DELAY, 2, clock edges between start acceptance and snapshot; 0 means snapshot on the acceptance edge.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  frame request; sampled only in IDLE.
- in_im  input  OUT_H*OUT_W*PIX_W  parallel result; pixel (r,c) is in_im[PIX_W*(OUT_W*r+c) +: PIX_W].
- busy  output  1  high in WAIT or STREAM.
- pix_data  output  PIX_W  current pixel.
- pix_valid  output  1  pix_data valid.
- pix_ready  input  1  consumer accepts when pix_valid && pix_ready (handshake).
- pix_row  output  5  row index of pix_data.
- pix_col  output  5  column index of pix_data.
- pix_eol  output  1  high with the last pixel of each row (pix_col==OUT_W-1).
- pix_last  output  1  high with the final pixel of the frame.
- frame_done  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (rst_n==0 at a clock edge):
  - State goes to IDLE.
  - busy, pix_valid, pix_eol, pix_last and frame_done go to 0.
  - pix_data, pix_row, pix_col, the snapshot and the counters go to 0.
  - Reset mid-frame aborts the frame; no frame_done is issued.
- State IDLE:
  - start==1 at edge T moves the FSM to WAIT and loads the delay counter with CAPTURE_DELAY.
  - With CAPTURE_DELAY==0, the FSM moves directly to STREAM and the snapshot is taken at edge T.
- State WAIT:
  - The counter decrements each edge.
  - When it reaches 0, in_im is captured into the snapshot shift register at edge T+CAPTURE_DELAY and the FSM enters STREAM.
  - pix_valid is high after that edge, showing pixel (0,0).
  - start is ignored.
- State STREAM:
  - pix_data is always snapshot[PIX_W-1:0].
  - On each handshake, the snapshot shifts right by PIX_W.
  - The column index advances, wrapping from OUT_W-1 to 0 and incrementing the row.
  - While pix_valid && !pix_ready, pix_data, pix_row, pix_col, pix_eol and pix_last hold stable.
  - On the handshake of pixel (OUT_H-1,OUT_W-1), the next edge sets pix_valid=0, busy=0, frame_done=1 and returns to IDLE.
  - start is ignored.
- frame_done:
  - Lasts exactly one cycle.
  - The FSM is already IDLE during that cycle, so a start sampled then is accepted (back-to-back frames).
- Throughput: with pix_ready held at 1, one pixel per cycle; 900 pixels in 900 consecutive cycles.
- in_im may change freely after the snapshot edge; the streamed data is unaffected.
- Consumer-side pix_ready toggling has no effect outside STREAM.

Optional Feature:
- Macro: CONV_OUT_STREAMER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [15:0].
  - checksum is a 16-bit wrapping sum of every handshaken pixel, zero-extended.
  - It clears on start acceptance and on reset.
  - The final value is valid while frame_done==1 and holds until the next start.
- When undefined: the port and the accumulator are absent; all other behaviour is identical.

Test Plan:
- Ramp frame, pixel (r,c)=30r+c, CAPTURE_DELAY=2, pix_ready=1, start at edge T:
  - pix_valid rises after edge T+2 with data 0, row 0, col 0.
  - 900 consecutive pixels 0..899 in order.
  - pix_eol on cols 29; pix_last on 899.
  - frame_done pulse at T+902; checksum 0x2C46 when the macro is defined.
- Backpressure: pix_ready=0 for 5 cycles while pixel 31 (row 1, col 1) is presented:
  - data 31, row 1, col 1 stay stable.
  - After release the next pixel is 32; no loss or duplication.
- Snapshot isolation: change in_im to all 0x1FFF one cycle after the snapshot edge:
  - The streamed frame is still the ramp.
- Start during STREAM (pixel 100) is ignored: exactly 900 pixels and one frame_done.
  - Start asserted in the frame_done cycle begins a second frame with pixel 0.
- Reset mid-frame: rst_n=0 for 1 edge after 400 handshakes:
  - pix_valid=0, busy=0, no frame_done.
  - A new start restreams from pixel 0.
- CAPTURE_DELAY=0: start at edge T gives pix_valid=1 with pixel 0 after edge T.
